// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with single-outstanding memory port and 2-entry prefetch FIFO
module if_stage #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        brj_i,
    input  logic [31:0] brj_pc_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic [31:0] d_instruction_o,
    output logic [31:0] d_pc_o,
    output logic [31:0] d_pc4_o,
    output logic        d_valid_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_KILL} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fpc;
    logic [31:0] req_pc;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        fire;
    logic        kept;
    logic        bypass;
    logic        push;
    logic        pop;
    logic        unused_brj_lsb;

    // Redirect targets are forced to word alignment, so the low bits are dropped.
    assign unused_brj_lsb = ^brj_pc_i[1:0];

    assign instr_addr_o = fpc;
    assign fire   = instr_req_o & instr_gnt_i;
    // A response is kept only while the FSM still wants it and no redirect kills it now.
    assign kept   = instr_rvalid_i & (state == S_WAIT) & ~brj_i;
    assign bypass = kept & (count == 2'd0) & ~stall_i;
    assign push   = kept & ~bypass;
    assign pop    = ~brj_i & ~stall_i & (count != 2'd0);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: a new grant while the current response retires keeps us in WAIT
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fire) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (instr_rvalid_i)  state_nxt = fire ? S_WAIT : S_IDLE;
                else if (brj_i)      state_nxt = S_KILL;
            end
            S_KILL: begin
                if (instr_rvalid_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM output: in WAIT a follow-on request is raised only in the cycle the current
    // response retires, so one request is in flight at most and FIFO space stays reserved
    always_comb begin
        instr_req_o = 1'b0;
        case (state)
            S_IDLE:  instr_req_o = (count != 2'd2);
            S_WAIT:  instr_req_o = instr_rvalid_i & (count == 2'd0);
            default: instr_req_o = 1'b0;
        endcase
        if (brj_i || !rst_n) instr_req_o = 1'b0;
    end

    // Fetch PC advances on each accepted request; redirect overrides
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc    <= BOOT_ADDR;
            req_pc <= BOOT_ADDR;
        end else begin
            if (brj_i)     fpc <= {brj_pc_i[31:2], 2'b00};
            else if (fire) fpc <= fpc + 32'd4;
            if (fire)      req_pc <= fpc;
        end
    end

    // FIFO storage, no reset needed since occupancy qualifies every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= instr_rdata_i;
            fifo_pc[wr_ptr]    <= req_pc;
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (brj_i) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Decode register: redirect bubbles, stall holds, else FIFO head, bypass, or bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_instruction_o <= NOP_INSTR;
            d_pc_o          <= 32'd0;
            d_pc4_o         <= 32'd0;
            d_valid_o       <= 1'b0;
        end else if (brj_i) begin
            d_instruction_o <= NOP_INSTR;
            d_valid_o       <= 1'b0;
        end else if (!stall_i) begin
            if (pop) begin
                d_instruction_o <= fifo_instr[rd_ptr];
                d_pc_o          <= fifo_pc[rd_ptr];
                d_pc4_o         <= fifo_pc[rd_ptr] + 32'd4;
                d_valid_o       <= 1'b1;
            end else if (bypass) begin
                d_instruction_o <= instr_rdata_i;
                d_pc_o          <= req_pc;
                d_pc4_o         <= req_pc + 32'd4;
                d_valid_o       <= 1'b1;
            end else begin
                d_instruction_o <= NOP_INSTR;
                d_valid_o       <= 1'b0;
            end
        end
    end

    // Request gating must make a push into a full FIFO unreachable
    assert property (@(posedge clk) disable iff (!rst_n) !(push && count == 2'd2));

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        brj_i;
    logic [31:0] brj_pc_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic [31:0] d_instruction_o;
    logic [31:0] d_pc_o;
    logic [31:0] d_pc4_o;
    logic        d_valid_o;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic        pend   = 1'b0;
    logic [31:0] paddr  = 32'd0;
    logic        rsp_hold = 1'b0;

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .brj_i          (brj_i),
        .brj_pc_i       (brj_pc_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .d_instruction_o(d_instruction_o),
        .d_pc_o         (d_pc_o),
        .d_pc4_o        (d_pc4_o),
        .d_valid_o      (d_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample the bus mid-cycle, then present the memory response after the edge
    task automatic cyc();
        logic        g;
        logic        r;
        logic [31:0] ga;
        @(negedge clk);
        g  = instr_req_o & instr_gnt_i;
        ga = instr_addr_o;
        r  = instr_rvalid_i;
        @(posedge clk);
        #1;
        if (r) pend = 1'b0;
        if (g) begin
            pend  = 1'b1;
            paddr = ga;
        end
        instr_rvalid_i = pend & ~rsp_hold;
        instr_rdata_i  = mem(paddr);
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; brj_i = 1'b0; brj_pc_i = 32'd0;
        instr_gnt_i = 1'b1; instr_rvalid_i = 1'b0; instr_rdata_i = 32'd0;

        cyc(); cyc(); #1;
        chk("rst_req", instr_req_o, 0);
        chk("rst_addr", instr_addr_o, 32'h0);
        chk("rst_instr", d_instruction_o, NOP);
        chk("rst_pc", d_pc_o, 0);
        chk("rst_pc4", d_pc4_o, 0);
        chk("rst_valid", d_valid_o, 0);

        rst_n = 1'b1; #1;
        chk("c0_req", instr_req_o, 1);
        chk("c0_addr", instr_addr_o, 32'h0);
        cyc(); #1;
        chk("c1_addr", instr_addr_o, 32'h4);
        chk("c1_valid", d_valid_o, 0);
        cyc(); #1;
        chk("c2_addr", instr_addr_o, 32'h8);
        chk("c2_pc", d_pc_o, 32'h0);
        chk("c2_instr", d_instruction_o, 32'hC0DE_0000);
        chk("c2_pc4", d_pc4_o, 32'h4);
        chk("c2_valid", d_valid_o, 1);
        cyc(); #1;
        chk("c3_pc", d_pc_o, 32'h4);
        chk("c3_pc4", d_pc4_o, 32'h8);
        cyc(); #1;
        chk("c4_pc", d_pc_o, 32'h8);
        chk("c4_pc4", d_pc4_o, 32'hC);
        chk("c4_addr", instr_addr_o, 32'h10);
        cyc(); #1;
        chk("c5_pc", d_pc_o, 32'hC);

        // stall while 0x10 sits in decode
        cyc(); stall_i = 1'b1; #1;
        chk("stall0_pc", d_pc_o, 32'h10);
        chk("stall0_instr", d_instruction_o, 32'hC0DE_0010);
        cyc(); #1;
        chk("stall1_req", instr_req_o, 0);
        chk("stall1_pc", d_pc_o, 32'h10);
        cyc(); #1;
        chk("stall2_req", instr_req_o, 0);
        chk("stall2_pc", d_pc_o, 32'h10);
        cyc(); stall_i = 1'b0; #1;
        chk("unstall_req", instr_req_o, 0);
        chk("unstall_pc", d_pc_o, 32'h10);
        cyc(); #1;
        chk("pop0_pc", d_pc_o, 32'h14);
        chk("pop0_instr", d_instruction_o, 32'hC0DE_0014);
        chk("pop0_valid", d_valid_o, 1);
        chk("pop0_addr", instr_addr_o, 32'h1C);
        cyc(); #1;
        chk("pop1_pc", d_pc_o, 32'h18);

        // redirect while 0x20 is outstanding with no response yet
        rsp_hold = 1'b1;
        cyc(); brj_i = 1'b1; brj_pc_i = 32'h103; #1;
        chk("brj_pc_before", d_pc_o, 32'h1C);
        chk("brj_req", instr_req_o, 0);
        rsp_hold = 1'b0;
        cyc(); brj_i = 1'b0; #1;
        chk("kill_valid", d_valid_o, 0);
        chk("kill_instr", d_instruction_o, NOP);
        chk("kill_req", instr_req_o, 0);
        cyc(); #1;
        chk("redir_req", instr_req_o, 1);
        chk("redir_addr", instr_addr_o, 32'h100);
        chk("redir_valid", d_valid_o, 0);
        cyc(); #1;
        chk("redir1_valid", d_valid_o, 0);
        chk("redir1_addr", instr_addr_o, 32'h104);

        // redirect coincident with a kept response and stall
        cyc(); stall_i = 1'b1; brj_i = 1'b1; brj_pc_i = 32'h200; #1;
        chk("tgt_pc", d_pc_o, 32'h100);
        chk("tgt_instr", d_instruction_o, 32'hC0DE_0100);
        chk("tgt_pc4", d_pc4_o, 32'h104);
        chk("tgt_valid", d_valid_o, 1);
        chk("coin_req", instr_req_o, 0);
        cyc(); stall_i = 1'b0; brj_i = 1'b0; #1;
        chk("coin_valid", d_valid_o, 0);
        chk("coin_instr", d_instruction_o, NOP);
        chk("coin_req2", instr_req_o, 1);
        chk("coin_addr", instr_addr_o, 32'h200);
        cyc(); #1;
        chk("coin1_valid", d_valid_o, 0);

        // wrap from the top of the address space
        cyc(); brj_i = 1'b1; brj_pc_i = 32'hFFFF_FFFE; #1;
        chk("c200_pc", d_pc_o, 32'h200);
        chk("c200_valid", d_valid_o, 1);
        cyc(); brj_i = 1'b0; #1;
        chk("wrap_addr", instr_addr_o, 32'hFFFF_FFFC);
        chk("wrap_req", instr_req_o, 1);
        cyc(); #1;
        chk("wrap_next", instr_addr_o, 32'h0);
        cyc(); brj_i = 1'b1; brj_pc_i = 32'h40; instr_gnt_i = 1'b0; #1;
        chk("wrap_pc", d_pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc4", d_pc4_o, 32'h0);
        chk("wrap_instr", d_instruction_o, 32'hC0DE_FFFC);
        chk("wrap_valid", d_valid_o, 1);

        // grant withheld for four cycles on 0x40
        cyc(); brj_i = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("gd_req", instr_req_o, 1);
            chk("gd_addr", instr_addr_o, 32'h40);
            chk("gd_valid", d_valid_o, 0);
            if (i < 3) begin
                cyc(); #1;
            end
        end
        cyc(); instr_gnt_i = 1'b1; #1;
        chk("gd_grant_addr", instr_addr_o, 32'h40);
        cyc(); instr_gnt_i = 1'b0; #1;
        chk("gd_rsp_addr", instr_addr_o, 32'h44);
        chk("gd_rsp_valid", d_valid_o, 0);
        cyc(); instr_gnt_i = 1'b1; #1;
        chk("gd_pc", d_pc_o, 32'h40);
        chk("gd_instr", d_instruction_o, 32'hC0DE_0040);
        chk("gd_nodup", instr_addr_o, 32'h44);

        // reset while 0x44 is outstanding; its late response must be ignored
        rsp_hold = 1'b1;
        cyc(); rst_n = 1'b0; #1;
        chk("mrst_req", instr_req_o, 0);
        chk("mrst_addr", instr_addr_o, 32'h0);
        chk("mrst_valid", d_valid_o, 0);
        chk("mrst_pc", d_pc_o, 32'h0);
        rsp_hold = 1'b0;
        cyc(); rst_n = 1'b1; #1;
        chk("mrst_rel_req", instr_req_o, 1);
        chk("mrst_rel_addr", instr_addr_o, 32'h0);
        cyc(); #1;
        chk("stale_valid", d_valid_o, 0);
        chk("stale_instr", d_instruction_o, NOP);
        cyc(); #1;
        chk("mrst_pc0", d_pc_o, 32'h0);
        chk("mrst_instr0", d_instruction_o, 32'hC0DE_0000);
        chk("mrst_valid0", d_valid_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
